detector_frame_filter: RTL and testbench

- Sits directly downstream of the UART receiver and upstream of the car controller's detector inputs and fork/barrier logic.
- Consumes received status bytes and validates framing.
- Debounces each of the four detector bits across consecutive frames.
- Tracks link health and substitutes a safe "all blocked" detector pattern when the link is down, so the controller never acts on garbage or stale data.

---
 rtl/detector_frame_filter_if.sv | 9 +
 rtl/detector_frame_filter.sv | 158 +++++++++++++++
 tb/tb_detector_frame_filter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/detector_frame_filter_if.sv
// Receive-side byte bus between the UART receiver and detector_frame_filter.
// The master drives a received byte together with a one-cycle valid strobe.
interface detector_frame_filter_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/detector_frame_filter.sv
// Validates received status frames, debounces the four detector bits and tracks
// link health. Optional even-parity check on bit 7 is enabled by FRAME_PARITY_EN.
module detector_frame_filter #(
    parameter logic [2:0] HDR             = 3'b000,
    parameter int         DEBOUNCE_FRAMES = 3,
    parameter int         SYNC_FRAMES     = 4,
    parameter int         TIMEOUT_CYCLES  = 2000000
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    detector_frame_filter_if.slave  rx,
    output logic                    front_detector,
    output logic                    left_detector,
    output logic                    right_detector,
    output logic                    back_detector,
    output logic                    fork_here,
    output logic                    link_up,
    output logic                    frame_err,
    output logic                    det_changed
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {DOWN, SYNC, UP} state_t;

    state_t        state, state_n;
    logic [3:0]    sync_cnt, sync_cnt_n;
    logic [3:0]    stable, stable_n;
    logic [3:0]    deb_cnt [4];
    logic [3:0]    deb_cnt_n [4];
    logic [TW-1:0] timeout_cnt, timeout_cnt_n;
    logic [3:0]    det_q, det_n;
    logic          fork_q, fork_n;
    logic          err_q, err_n;
    logic          chg_q, chg_n;
    logic          parity_ok, good, bad, timeout_hit;

`ifdef FRAME_PARITY_EN
    assign parity_ok = (rx.rx_data[7] == ^rx.rx_data[6:0]);
`else
    logic parity_unused;
    assign parity_unused = rx.rx_data[7];
    assign parity_ok     = 1'b1;
`endif

    assign good        = rx.rx_valid && (rx.rx_data[6:4] == HDR) && parity_ok;
    assign bad         = rx.rx_valid && !good;
    // The cycle in which the idle counter would reach the limit is the drop cycle.
    assign timeout_hit = !good && (state != DOWN) && (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_n       = state;
        sync_cnt_n    = sync_cnt;
        stable_n      = stable;
        deb_cnt_n     = deb_cnt;
        timeout_cnt_n = timeout_cnt;

        if (good)
            timeout_cnt_n = '0;
        else if (timeout_cnt != TW'(TIMEOUT_CYCLES))
            timeout_cnt_n = timeout_cnt + 1'b1;

        case (state)
            DOWN: begin
                if (good) begin
                    if (SYNC_FRAMES == 1) begin
                        state_n    = UP;
                        sync_cnt_n = '0;
                        stable_n   = rx.rx_data[3:0];
                        for (int i = 0; i < 4; i++) deb_cnt_n[i] = '0;
                    end else begin
                        state_n    = SYNC;
                        sync_cnt_n = 4'd1;
                    end
                end
            end
            SYNC: begin
                if (good) begin
                    if (sync_cnt + 4'd1 == 4'(SYNC_FRAMES)) begin
                        state_n    = UP;
                        sync_cnt_n = '0;
                        stable_n   = rx.rx_data[3:0];
                        for (int i = 0; i < 4; i++) deb_cnt_n[i] = '0;
                    end else begin
                        sync_cnt_n = sync_cnt + 4'd1;
                    end
                end else if (bad || timeout_hit) begin
                    state_n    = DOWN;
                    sync_cnt_n = '0;
                    if (timeout_hit) begin
                        timeout_cnt_n = '0;
                        for (int i = 0; i < 4; i++) deb_cnt_n[i] = '0;
                    end
                end
            end
            UP: begin
                if (good) begin
                    for (int i = 0; i < 4; i++) begin
                        if (rx.rx_data[i] == stable[i]) begin
                            deb_cnt_n[i] = '0;
                        end else if (deb_cnt[i] + 4'd1 == 4'(DEBOUNCE_FRAMES)) begin
                            stable_n[i]  = ~stable[i];
                            deb_cnt_n[i] = '0;
                        end else begin
                            deb_cnt_n[i] = deb_cnt[i] + 4'd1;
                        end
                    end
                end else if (timeout_hit) begin
                    state_n       = DOWN;
                    sync_cnt_n    = '0;
                    timeout_cnt_n = '0;
                    for (int i = 0; i < 4; i++) deb_cnt_n[i] = '0;
                end
            end
            default: state_n = DOWN;
        endcase

        // Entering UP reveals the first real pattern; that is not a debounced flip.
        det_n  = (state_n == UP) ? stable_n : 4'hF;
        chg_n  = (det_n != det_q) && !((state != UP) && (state_n == UP));
        err_n  = bad;
        fork_n = !det_q[0] && (!det_q[1] || !det_q[2]);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state       <= DOWN;
            sync_cnt    <= '0;
            stable      <= 4'hF;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
            timeout_cnt <= '0;
            det_q       <= 4'hF;
            fork_q      <= 1'b0;
            err_q       <= 1'b0;
            chg_q       <= 1'b0;
        end else begin
            state       <= state_n;
            sync_cnt    <= sync_cnt_n;
            stable      <= stable_n;
            deb_cnt     <= deb_cnt_n;
            timeout_cnt <= timeout_cnt_n;
            det_q       <= det_n;
            fork_q      <= fork_n;
            err_q       <= err_n;
            chg_q       <= chg_n;
        end
    end

    assign front_detector = det_q[0];
    assign left_detector  = det_q[1];
    assign right_detector = det_q[2];
    assign back_detector  = det_q[3];
    assign fork_here      = fork_q;
    assign link_up        = (state == UP);
    assign frame_err      = err_q;
    assign det_changed    = chg_q;

endmodule

// File: tb/tb_detector_frame_filter.sv
// Directed bench for detector_frame_filter with a shortened timeout so the
// link-loss scenarios finish quickly; honours FRAME_PARITY_EN like the RTL.
module tb_detector_frame_filter;

    localparam int T = 200;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    logic front_detector, left_detector, right_detector, back_detector;
    logic fork_here, link_up, frame_err, det_changed;
    logic [3:0] det;
    int vectors = 0;
    int miscompares = 0;
    int chg_cnt = 0;
    int err_cnt = 0;

    detector_frame_filter_if rx_if ();

    detector_frame_filter #(.TIMEOUT_CYCLES(T)) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .rx             (rx_if.slave),
        .front_detector (front_detector),
        .left_detector  (left_detector),
        .right_detector (right_detector),
        .back_detector  (back_detector),
        .fork_here      (fork_here),
        .link_up        (link_up),
        .frame_err      (frame_err),
        .det_changed    (det_changed)
    );

    always #5 sys_clk = ~sys_clk;

    assign det = {back_detector, right_detector, left_detector, front_detector};

    // Pulse counters sampled mid-cycle so every one-cycle pulse is counted once.
    always @(negedge sys_clk) begin
        if (det_changed === 1'b1) chg_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b);
        @(negedge sys_clk);
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        rx_if.rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_if.rx_valid = 1'b0;
        idle(2);
        @(negedge sys_clk);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;
        idle(2);
        vectors++; if (det !== 4'hF) begin miscompares++; $display("[TB] FAIL reset_det got %h want f", det); end
        vectors++; if (link_up !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_link got %b want 0", link_up); end
        vectors++; if ({fork_here, frame_err, det_changed} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_pulses got %b want 000", {fork_here, frame_err, det_changed}); end
        @(negedge sys_clk);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_sync_up();
        int c0;
        c0 = chg_cnt;
        for (int i = 0; i < 3; i++) begin
            send_frame(8'h0A);
            vectors++; if (link_up !== 1'b0) begin miscompares++; $display("[TB] FAIL sync_link_early frame %0d got %b want 0", i, link_up); end
            vectors++; if (det !== 4'hF) begin miscompares++; $display("[TB] FAIL sync_det_forced frame %0d got %h want f", i, det); end
            idle(100);
        end
        send_frame(8'h0A);
        vectors++; if (link_up !== 1'b1) begin miscompares++; $display("[TB] FAIL sync_link_up got %b want 1", link_up); end
        vectors++; if (det !== 4'hA) begin miscompares++; $display("[TB] FAIL sync_det got %h want a", det); end
        vectors++; if (fork_here !== 1'b0) begin miscompares++; $display("[TB] FAIL fork_lag got %b want 0", fork_here); end
        idle(1);
        vectors++; if (fork_here !== 1'b1) begin miscompares++; $display("[TB] FAIL fork_set got %b want 1", fork_here); end
        idle(2);
        vectors++; if (chg_cnt - c0 !== 0) begin miscompares++; $display("[TB] FAIL sync_no_change got %0d pulses want 0", chg_cnt - c0); end
    endtask

    task automatic test_debounce();
        int c0;
        c0 = chg_cnt;
        send_frame(8'h0B);
        send_frame(8'h0B);
        vectors++; if (front_detector !== 1'b0) begin miscompares++; $display("[TB] FAIL deb_two got %b want 0", front_detector); end
        send_frame(8'h0A);
        vectors++; if (front_detector !== 1'b0) begin miscompares++; $display("[TB] FAIL deb_clear got %b want 0", front_detector); end
        send_frame(8'h0B);
        send_frame(8'h0B);
        vectors++; if (front_detector !== 1'b0) begin miscompares++; $display("[TB] FAIL deb_after_clear got %b want 0", front_detector); end
        send_frame(8'h0B);
        vectors++; if (det !== 4'hB) begin miscompares++; $display("[TB] FAIL deb_flip got %h want b", det); end
        vectors++; if (det_changed !== 1'b1) begin miscompares++; $display("[TB] FAIL deb_pulse got %b want 1", det_changed); end
        idle(2);
        vectors++; if (chg_cnt - c0 !== 1) begin miscompares++; $display("[TB] FAIL deb_pulse_count got %0d want 1", chg_cnt - c0); end
        vectors++; if (fork_here !== 1'b0) begin miscompares++; $display("[TB] FAIL deb_fork got %b want 0", fork_here); end
        send_frame(8'h1A);
        vectors++; if ({frame_err, link_up} !== 2'b11) begin miscompares++; $display("[TB] FAIL up_bad_frame err/link got %b want 11", {frame_err, link_up}); end
        vectors++; if (det !== 4'hB) begin miscompares++; $display("[TB] FAIL up_bad_det got %h want b", det); end
    endtask

    task automatic test_async_reset();
        @(negedge sys_clk);
        #2 rst = 1'b1;
        #1;
        vectors++; if ({link_up, det} !== 5'b0_1111) begin miscompares++; $display("[TB] FAIL async_reset got %b want 01111", {link_up, det}); end
        @(negedge sys_clk);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_bad_in_sync();
        send_frame(8'h0A);
        idle(3);
        send_frame(8'h0A);
        idle(3);
        send_frame(8'h1A);
        vectors++; if (frame_err !== 1'b1) begin miscompares++; $display("[TB] FAIL sync_bad_err got %b want 1", frame_err); end
        vectors++; if ({link_up, det} !== 5'b0_1111) begin miscompares++; $display("[TB] FAIL sync_bad_state got %b want 01111", {link_up, det}); end
        idle(1);
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL sync_bad_err_len got %b want 0", frame_err); end
        for (int i = 0; i < 3; i++) send_frame(8'h0A);
        vectors++; if (link_up !== 1'b0) begin miscompares++; $display("[TB] FAIL resync_early got %b want 0", link_up); end
        send_frame(8'h0A);
        vectors++; if ({link_up, det} !== 5'b1_1010) begin miscompares++; $display("[TB] FAIL resync_up got %b want 11010", {link_up, det}); end
    endtask

    task automatic test_timeout();
        idle(T - 1);
        vectors++; if (link_up !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_early got %b want 1", link_up); end
        idle(1);
        vectors++; if ({link_up, det} !== 5'b0_1111) begin miscompares++; $display("[TB] FAIL timeout_drop got %b want 01111", {link_up, det}); end
        vectors++; if (det_changed !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_pulse got %b want 1", det_changed); end
    endtask

    task automatic test_timeout_race();
        for (int i = 0; i < 4; i++) send_frame(8'h0A);
        vectors++; if (link_up !== 1'b1) begin miscompares++; $display("[TB] FAIL race_setup got %b want 1", link_up); end
        idle(T - 1);
        send_frame(8'h0A);
        vectors++; if ({link_up, det_changed} !== 2'b10) begin miscompares++; $display("[TB] FAIL race_frame_wins got %b want 10", {link_up, det_changed}); end
        idle(T - 1);
        vectors++; if (link_up !== 1'b1) begin miscompares++; $display("[TB] FAIL race_restart got %b want 1", link_up); end
        idle(1);
        vectors++; if (link_up !== 1'b0) begin miscompares++; $display("[TB] FAIL race_later_drop got %b want 0", link_up); end
    endtask

    task automatic test_parity();
        int e0;
        do_reset();
        e0 = err_cnt;
        send_frame(8'h0A);
        idle(3);
        send_frame(8'h8A);
        idle(3);
        send_frame(8'h0A);
        idle(3);
        send_frame(8'h8A);
        idle(2);
`ifdef FRAME_PARITY_EN
        vectors++; if (err_cnt - e0 !== 2) begin miscompares++; $display("[TB] FAIL parity_errs got %0d want 2", err_cnt - e0); end
        vectors++; if (link_up !== 1'b0) begin miscompares++; $display("[TB] FAIL parity_link got %b want 0", link_up); end
`else
        vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("[TB] FAIL parity_errs got %0d want 0", err_cnt - e0); end
        vectors++; if (link_up !== 1'b1) begin miscompares++; $display("[TB] FAIL parity_link got %b want 1", link_up); end
`endif
    endtask

    initial begin
        rx_if.rx_data  = 8'h00;
        rx_if.rx_valid = 1'b0;
        test_reset();
        test_sync_up();
        test_debounce();
        test_async_reset();
        test_bad_in_sync();
        test_timeout();
        test_timeout_race();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
